uart_rx_ctrl: RTL

Controller that sits between the bus-side register logic and the UART receiver. It owns the receiver's bit-period configuration and its active-low reset, so the receiver can be enabled and disabled safely. It buffers received bytes in a small FIFO with a pop handshake, and raises watermark, overflow and idle-timeout interrupts.

---
 rtl/uart_pkg.sv | 7 +
 rtl/uart_rx_ctrl_if.sv | 8 +
 rtl/uart_rx_fifo.sv | 37 +++
 rtl/uart_rx_ctrl.sv | 98 +++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared state type and constants for the UART receive controller.
package uart_pkg;
  typedef enum logic [1:0] {DISABLED, ARMING, ACTIVE} rx_ctrl_state_e;
  localparam logic [15:0] CPB_MIN = 16'd4;
  localparam int ARM_CYCLES = 2;
  localparam int TO_BIT_TIMES = 32;
endpackage

// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if: FIFO pop handshake between bus-side register logic and the controller.
interface uart_rx_ctrl_if;
  logic rd_req_i;
  logic rd_valid_o;
  logic [7:0] rd_data_o;
  modport master (output rd_req_i, input rd_valid_o, rd_data_o);
  modport slave (input rd_req_i, output rd_valid_o, rd_data_o);
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous byte FIFO with registered pop output and flush.
module uart_rx_fifo #(
  parameter int DEPTH = 8,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  logic [7:0]    wdata_i,
  output logic          rvalid_o,
  output logic [7:0]    rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [LW-1:0] level_o
);
  logic [7:0] mem [DEPTH];
  logic [LW-1:0] wr_cnt, rd_cnt;
  assign level_o = wr_cnt - rd_cnt;
  assign full_o = level_o == LW'(DEPTH);
  assign empty_o = level_o == '0;
  always_ff @(posedge clk_i)
    if (push_i && !flush_i) mem[wr_cnt[LW-2:0]] <= wdata_i;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
      rvalid_o <= 1'b0;
      rdata_o <= '0;
    end else begin
      wr_cnt <= flush_i ? '0 : wr_cnt + LW'(push_i);
      rd_cnt <= flush_i ? '0 : rd_cnt + LW'(pop_i);
      rvalid_o <= pop_i && !flush_i;
      if (pop_i && !flush_i) rdata_o <= mem[rd_cnt[LW-2:0]];
    end
endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: receiver enable/arming FSM, bit-period config, RX FIFO and interrupts.
// Optional idle timeout built when UART_RX_TIMEOUT_EN is defined.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter logic [15:0] DEFAULT_CPB = 16'd87,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           cfg_en_i,
  input  logic           cfg_we_i,
  input  logic [15:0]    cfg_wdata_i,
  output logic           cfg_err_o,
  output logic [15:0]    clks_per_bit_o,
  output logic           rx_rst_no,
  input  logic           rx_dv_i,
  input  logic [7:0]     rx_byte_i,
  uart_rx_ctrl_if.slave  rd,
  input  logic           flush_i,
  output logic [LW-1:0]  level_o,
  input  logic [LW-1:0]  watermark_i,
  output logic           intr_wm_o,
  output logic           intr_ovf_o,
  input  logic           ovf_clr_i,
  output logic           intr_to_o
);
  rx_ctrl_state_e state;
  logic arm_cnt, full, empty, push_req, push, pop, ovf_set;
  assign push_req = rx_dv_i && state == ACTIVE;
  assign pop = rd.rd_req_i && !empty && !flush_i;
  assign push = push_req && (!full || pop);
  assign ovf_set = push_req && full && !pop && !flush_i;
  assign intr_wm_o = watermark_i != '0 && level_o >= watermark_i;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state <= DISABLED;
      arm_cnt <= 1'b0;
      rx_rst_no <= 1'b0;
      clks_per_bit_o <= DEFAULT_CPB;
      cfg_err_o <= 1'b0;
      intr_ovf_o <= 1'b0;
    end else begin
      cfg_err_o <= cfg_we_i && state != DISABLED;
      if (cfg_we_i && state == DISABLED) clks_per_bit_o <= cfg_wdata_i < CPB_MIN ? CPB_MIN : cfg_wdata_i;
      intr_ovf_o <= ovf_set || (intr_ovf_o && !ovf_clr_i);
      if (!cfg_en_i) begin
        state <= DISABLED;
        rx_rst_no <= 1'b0;
        arm_cnt <= 1'b0;
      end else if (state == DISABLED) begin
        state <= ARMING;
        rx_rst_no <= 1'b1;
        arm_cnt <= 1'b0;
      end else if (state == ARMING) begin
        arm_cnt <= arm_cnt + 1'b1;
        if (arm_cnt == 1'(ARM_CYCLES - 1)) state <= ACTIVE;
      end
    end
  uart_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .push_i   (push),
    .pop_i    (pop),
    .flush_i  (flush_i),
    .wdata_i  (rx_byte_i),
    .rvalid_o (rd.rd_valid_o),
    .rdata_o  (rd.rd_data_o),
    .full_o   (full),
    .empty_o  (empty),
    .level_o  (level_o)
  );
`ifdef UART_RX_TIMEOUT_EN
  // Idle is measured in whole bit times so the timeout tracks the configured baud rate.
  logic [15:0] tick;
  logic [4:0] bits;
  rx_ctrl_state_e state_d;
  logic activity, restart, bit_done;
  assign activity = push || pop || flush_i;
  assign restart = activity || state != state_d;
  assign bit_done = tick == clks_per_bit_o - 16'd1;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      tick <= '0;
      bits <= '0;
      state_d <= DISABLED;
      intr_to_o <= 1'b0;
    end else begin
      state_d <= state;
      tick <= (restart || bit_done) ? '0 : tick + 16'd1;
      bits <= restart ? '0 : bits + 5'(bit_done);
      intr_to_o <= activity ? 1'b0 : intr_to_o || (!restart && bit_done && bits == 5'(TO_BIT_TIMES - 1) && !empty && state == ACTIVE);
    end
`else
  assign intr_to_o = 1'b0;
`endif
endmodule
